// File: rtl/mult_pkg.sv
// Shared state encoding for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier: one partial product per clock, signed or
// unsigned operands, valid/ready on both sides.
module seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] res,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand, mplier;
    logic [2*WIDTH-1:0] acc, addend, acc_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic               accept, last;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    // The most-negative input negates to itself, which read as unsigned is the
    // correct magnitude 2^(WIDTH-1).
    assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    assign addend  = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
    assign acc_nxt = acc + addend;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)               state_nxt = ST_CALC;
            ST_CALC: if (last)                 state_nxt = ST_DONE;
            ST_DONE: if (out_valid && out_ready) state_nxt = ST_IDLE;
            default:                           state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state == ST_CALC) || (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            res    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                ST_CALC: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) res <= neg ? (~acc_nxt + 1'b1) : acc_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench: WIDTH=8 directed corners plus an exhaustive WIDTH=4 sweep
// checked against a combinational 4x4 reference.
module tb_seq_mult;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid8 = 1'b0, in_ready8, is_signed8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        out_valid8, out_ready8 = 1'b1, busy8;
    logic [15:0] res8;

    logic        in_valid4 = 1'b0, in_ready4, is_signed4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        out_valid4, out_ready4 = 1'b1, busy4;
    logic [7:0]  res4;

    seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .is_signed(is_signed8), .out_valid(out_valid8),
        .out_ready(out_ready8), .res(res8), .busy(busy8)
    );

    seq_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .is_signed(is_signed4), .out_valid(out_valid4),
        .out_ready(out_ready4), .res(res4), .busy(busy4)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] q8[$];
    logic [7:0]  q4[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the original 4x4 combinational partial-product adder tree.
    function automatic logic [7:0] comb4x4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] p0, p1, p2, p3;
        p0 = y[0] ? {4'b0, x}       : 8'd0;
        p1 = y[1] ? {3'b0, x, 1'b0} : 8'd0;
        p2 = y[2] ? {2'b0, x, 2'b0} : 8'd0;
        p3 = y[3] ? {1'b0, x, 3'b0} : 8'd0;
        return (p0 + p1) + (p2 + p3);
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid8 && out_ready8) begin
            if (q8.size() == 0) chk("unexpected_out8", res8, 16'hxxxx);
            else chk("res8", res8, q8.pop_front());
        end
        if (!rst && out_valid4 && out_ready4) begin
            if (q4.size() == 0) chk("unexpected_out4", {8'h0, res4}, 16'hxxxx);
            else chk("res4", {8'h0, res4}, {8'h0, q4.pop_front()});
        end
    end

    task automatic wait_ready8();
        int k;
        for (k = 0; k < 100 && !in_ready8; k++) begin
            @(posedge clk); #1;
        end
        if (!in_ready8) chk("timeout_in_ready8", 16'(in_ready8), 16'd1);
    endtask

    // Issue one WIDTH=8 op; the expected product is queued for the monitor.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp, input bit push);
        wait_ready8();
        a8 = a; b8 = b; is_signed8 = s; in_valid8 = 1'b1;
        if (push) q8.push_back(exp);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 16'(in_ready8), 16'd1);
        chk("rst_out_valid", 16'(out_valid8), 16'd0);
        chk("rst_busy", 16'(busy8), 16'd0);
        chk("rst_res", res8, 16'h0000);
        rst = 1'b0;

        // Latency from acceptance edge and return of in_ready.
        go8(8'd255, 8'd255, 1'b0, 16'd65025, 1);
        n = 0;
        while (!out_valid8 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 16'(n), 16'd8);
        @(posedge clk); #1;
        chk("in_ready_after_hs", 16'(in_ready8), 16'd1);

        go8(8'h80, 8'h80, 1'b1, 16'h4000, 1);
        go8(8'h80, 8'h7F, 1'b1, 16'hC080, 1);
        go8(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1);
        go8(8'h00, 8'hFF, 1'b1, 16'h0000, 1);
        go8(8'hFF, 8'hFF, 1'b1, 16'h0001, 1);

        // Backpressure: result must hold and new requests must be refused.
        wait_ready8();
        out_ready8 = 1'b0;
        go8(8'd9, 8'd10, 1'b0, 16'd90, 1);
        n = 0;
        while (!out_valid8 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            a8 = 8'd2; b8 = 8'd3; is_signed8 = 1'b0; in_valid8 = i[0];
            chk("bp_out_valid", 16'(out_valid8), 16'd1);
            chk("bp_res", res8, 16'd90);
            chk("bp_in_ready", 16'(in_ready8), 16'd0);
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after", 16'(in_ready8), 16'd1);
        go8(8'd2, 8'd3, 1'b0, 16'd6, 1);

        // Reset during the third CALC cycle drops the operation silently.
        wait_ready8();
        go8(8'd200, 8'd100, 1'b0, 16'd0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 16'(in_ready8), 16'd1);
        chk("midrst_busy", 16'(busy8), 16'd0);
        chk("midrst_res", res8, 16'h0000);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid8) seen = 1;
            @(posedge clk); #1;
        end
        chk("midrst_no_out", 16'(seen), 16'd0);
        go8(8'd7, 8'd9, 1'b0, 16'd63, 1);

        // Exhaustive WIDTH=4 unsigned sweep.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                n = 0;
                while (!in_ready4 && n < 100) begin
                    @(posedge clk); #1; n++;
                end
                if (!in_ready4) chk("timeout_in_ready4", 16'(in_ready4), 16'd1);
                a4 = 4'(x); b4 = 4'(y); in_valid4 = 1'b1;
                q4.push_back(comb4x4(4'(x), 4'(y)));
                @(posedge clk); #1;
                in_valid4 = 1'b0;
            end
        end

        n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_q8", 16'(q8.size()), 16'd0);
        chk("drain_q4", 16'(q4.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
Parametrised, sequential shift-and-add multiplier. Successor to the team's fixed 4x4 combinational multiplier. It generalises operand width, adds a signed/unsigned mode, and replaces the single-cycle adder tree with one partial product per clock behind valid/ready handshakes. It sits between operand-producing logic and result consumers in the datapath. A full-width product needs only one adder.

Parameters:
WIDTH, 8, operand width in bits (must be >= 2); product width is 2*WIDTH
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a, b, is_signed are valid this cycle
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
is_signed  input  1  1 = two's-complement operands/result, 0 = unsigned
out_valid  output  1  res holds a completed product
out_ready  input  1  consumer accepts res this cycle
res  output  2*WIDTH  product
busy  output  1  high in CALC or DONE

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, res=0, accumulator, operand registers and counter=0.
- Reset mid-operation: the operation is dropped with no output. The block returns to IDLE next cycle.
- States: IDLE, CALC, DONE. Encoding is 2-bit binary.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch |a| and |b| into mcand/mplier.
    - If is_signed, magnitude is the two's-complement negation when the MSB is set. Most-negative input gives magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits.
  - Store neg = is_signed & (a[MSB]^b[MSB]).
  - Clear accumulator and counter. Go to CALC.
- CALC: one iteration per cycle.
  - If mplier[0]: acc += mcand << cnt. Width is 2*WIDTH, zero-extended; no overflow is possible.
  - Then mplier >>= 1 and cnt++.
  - After exactly WIDTH iterations (cnt==WIDTH-1 on the last one): register res = neg ? -acc_final : acc_final, set out_valid=1, go to DONE.
  - Fixed latency, no early termination on zero operands.
- DONE:
  - out_valid=1; res is held stable until handshake.
  - On out_valid&&out_ready: out_valid=0, go to IDLE next cycle.
  - res keeps its last value after handshake, until the next completion or reset.
- Latency: operands accepted at edge t → out_valid high after edge t+WIDTH. That is WIDTH cycles in CALC, with the result visible in the first DONE cycle.
- Throughput: at most one operation per WIDTH+2 cycles (accept, WIDTH CALC cycles, DONE with immediate out_ready).
- in_valid in CALC/DONE is ignored; in_ready=0. Inputs a, b, is_signed are sampled only at acceptance.
- Simultaneous rst and any handshake: rst wins.
- Unsigned mode: res = a*b exactly, max (2^WIDTH-1)^2.
- Signed mode: res is the exact 2*WIDTH-bit two's-complement product. The range covers (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
- out_ready held high while not out_valid has no effect.

Decomposition:
- Package mult_pkg: state typedef/localparams (ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2).
- No sub-module is needed. Magnitude/negate are small inline expressions, and the single datapath adder sits in the CALC branch.
- Combinational test oracle: a WIDTH=4 configuration must match the existing combinational multiplier for all unsigned inputs.

Test Plan:
- Reset then idle, WIDTH=8: rst high 2 cycles → in_ready=1, out_valid=0, busy=0, res=16'h0000.
- Unsigned, WIDTH=8: a=8'd255, b=8'd255, is_signed=0, out_ready=1 → out_valid exactly 8 cycles after acceptance edge; res=16'd65025; in_ready returns next cycle.
- Signed corners, WIDTH=8:
  - a=-128, b=-128 → res=16'h4000.
  - a=-128, b=127 → res=16'hC080.
  - a=-3, b=5 → res=16'hFFF1.
  - a=0, b=-1 → res=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid → res and out_valid stable; in_valid pulses with a=2, b=3 ignored (in_ready=0); after out_ready=1, one cycle later in_ready=1 and the new operation gives res=6.
- Reset mid-CALC: accept a=200, b=100, assert rst at 3rd CALC cycle → next cycle IDLE, out_valid never rises, res=0; the following op a=7, b=9 gives res=63.
- Exhaustive WIDTH=4 unsigned sweep of all 256 pairs, with back-to-back handshakes → every res equals a*b (e.g. 15*15=225) and matches the combinational oracle.
